// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the unified memory arbiter: requester ids,
// func3 access modes, response tags and the alignment check.
package riscv_mem_pkg;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic valid;
        src_e src;
    } tag_t;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
        case (mode[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Response tag shift register: one {valid, src} entry per memory latency cycle.
// Flush drops fetch entries already in flight without touching the entry being pushed.
module arb_tag_pipe
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid_i,
    input  src_e push_src_i,
    input  logic flush_if_i,
    output tag_t tail_o
);

    tag_t [DEPTH-1:0] pipe_q;
    tag_t [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d          = '0;
        pipe_d[0].valid = push_valid_i;
        pipe_d[0].src   = push_src_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
            if (flush_if_i && (pipe_q[i-1].src == SRC_IF)) begin
                pipe_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-clock request/grant arbiter sharing one memory port between fetch and
// load/store, with starvation relief for fetch and tagged response routing.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_mode,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_err,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             grant_if;
    logic             grant_d;
    logic             d_misaligned;
    logic             read_push;
    src_e             push_src;
    tag_t             tail;

    assign d_misaligned = is_misaligned(d_mode, d_addr[1:0]);

    // Grants are held off during reset so every output reads 0 while rst is high.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst) begin
            if (if_req && (starve_cnt_q == CNT_W'(STARVE_MAX))) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_mode  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        push_src  = SRC_D;
        if (grant_if) begin
            mem_en   = 1'b1;
            mem_mode = F3_W;
            mem_addr = if_addr;
            push_src = SRC_IF;
        end else if (grant_d && !d_misaligned) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_mode  = d_mode;
            mem_addr  = d_addr;
            mem_wdata = d_we ? d_wdata : '0;
        end
    end

    assign read_push = mem_en && !mem_we;
    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign d_err     = grant_d && d_misaligned;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if || !if_req) begin
            starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    arb_tag_pipe #(
        .DEPTH(MEM_LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .push_valid_i(read_push),
        .push_src_i  (push_src),
        .flush_if_i  (if_flush),
        .tail_o      (tail)
    );

    // A flush also hides the fetch response arriving in the same cycle.
    assign if_rvalid = tail.valid && (tail.src == SRC_IF) && !if_flush;
    assign d_rvalid  = tail.valid && (tail.src == SRC_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (latency 1, 2, 3) share one
// stimulus stream; a byte-array memory serves each, and a queue model predicts responses.
module tb_unified_mem_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_mode;

    logic        if_gnt [NI];
    logic        if_rvalid [NI];
    logic [31:0] if_rdata [NI];
    logic        d_gnt [NI];
    logic        d_err [NI];
    logic        d_rvalid [NI];
    logic [31:0] d_rdata [NI];
    logic        mem_en [NI];
    logic        mem_we [NI];
    logic [2:0]  mem_mode [NI];
    logic [31:0] mem_addr [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] rd_pipe [NI][NI];

    logic [7:0]  mem [4096];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        unified_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(g + 1), .STARVE_MAX(4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
            .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(d_gnt[g]), .d_err(d_err[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_mode(mem_mode[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(rd_pipe[g][g])
        );
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] mode);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[12'(a + 32'(b))];
        case (mode)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Memory: reads land in a per-instance delay line, non-read cycles return junk.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            for (int i = NI - 1; i > 0; i--) rd_pipe[g][i] <= rd_pipe[g][i-1];
            rd_pipe[g][0] <= (mem_en[g] && !mem_we[g]) ? mem_rd(mem_addr[g], mem_mode[g]) : $urandom;
        end
        if (mem_en[0] && mem_we[0]) begin
            for (int b = 0; b < (1 << mem_mode[0][1:0]); b++)
                mem[12'(mem_addr[0] + 32'(b))] = mem_wdata[0][8*b +: 8];
        end
    end

    // Reference model: pending responses as {due cycle, requester, data, still wanted}.
    typedef struct {
        int          due;
        int          inst;
        bit          is_if;
        logic [31:0] data;
        bit          live;
    } rsp_t;

    rsp_t        rq [$];
    int          starve, cyc, errors, checks;
    logic        e_if_gnt, e_d_gnt, e_err, e_en, e_we;
    logic [2:0]  e_mode;
    logic [31:0] e_addr, e_wdata, e_data;
    logic        e_if_rv [NI];
    logic        e_d_rv [NI];
    logic [31:0] e_if_rd [NI];
    logic [31:0] e_d_rd [NI];

    function automatic bit misaligned(input logic [2:0] m, input logic [31:0] a);
        int n;
        n = 1 << m[1:0];
        return (a % n) != 0;
    endfunction

    task automatic settle();
        #3;
        e_if_gnt = 0; e_d_gnt = 0; e_err = 0; e_en = 0; e_we = 0;
        e_mode = 0; e_addr = 0; e_wdata = 0; e_data = 0;
        if (!rst) begin
            if (if_req && starve == 4) e_if_gnt = 1;
            else if (d_req)            e_d_gnt = 1;
            else if (if_req)           e_if_gnt = 1;
        end
        if (e_d_gnt) e_err = misaligned(d_mode, d_addr);
        if (e_if_gnt) begin
            e_en = 1; e_addr = if_addr; e_mode = 3'b010;
        end else if (e_d_gnt && !e_err) begin
            e_en = 1; e_we = d_we; e_addr = d_addr; e_mode = d_mode; e_wdata = d_wdata;
        end
        if (e_en && !e_we) e_data = mem_rd(e_addr, e_mode);
        if (if_flush && !rst) foreach (rq[k]) if (rq[k].is_if) rq[k].live = 0;
        for (int g = 0; g < NI; g++) begin
            e_if_rv[g] = 0; e_d_rv[g] = 0; e_if_rd[g] = 0; e_d_rd[g] = 0;
        end
        if (!rst) foreach (rq[k]) begin
            if (rq[k].due == cyc && rq[k].live) begin
                if (rq[k].is_if) begin e_if_rv[rq[k].inst] = 1; e_if_rd[rq[k].inst] = rq[k].data; end
                else             begin e_d_rv[rq[k].inst] = 1;  e_d_rd[rq[k].inst] = rq[k].data; end
            end
        end
        for (int g = 0; g < NI; g++) begin
            checks++; if (if_gnt[g] !== e_if_gnt) begin errors++; $display("FAIL if_gnt[%0d] cyc=%0d got=%b exp=%b", g, cyc, if_gnt[g], e_if_gnt); end
            checks++; if (d_gnt[g] !== e_d_gnt) begin errors++; $display("FAIL d_gnt[%0d] cyc=%0d got=%b exp=%b", g, cyc, d_gnt[g], e_d_gnt); end
            checks++; if (d_err[g] !== e_err) begin errors++; $display("FAIL d_err[%0d] cyc=%0d got=%b exp=%b", g, cyc, d_err[g], e_err); end
            checks++; if (mem_en[g] !== e_en) begin errors++; $display("FAIL mem_en[%0d] cyc=%0d got=%b exp=%b", g, cyc, mem_en[g], e_en); end
            checks++; if (mem_we[g] !== e_we) begin errors++; $display("FAIL mem_we[%0d] cyc=%0d got=%b exp=%b", g, cyc, mem_we[g], e_we); end
            if (e_en) begin
                checks++; if (mem_addr[g] !== e_addr) begin errors++; $display("FAIL mem_addr[%0d] cyc=%0d got=%h exp=%h", g, cyc, mem_addr[g], e_addr); end
                checks++; if (mem_mode[g] !== e_mode) begin errors++; $display("FAIL mem_mode[%0d] cyc=%0d got=%b exp=%b", g, cyc, mem_mode[g], e_mode); end
            end
            if (e_en && e_we) begin
                checks++; if (mem_wdata[g] !== e_wdata) begin errors++; $display("FAIL mem_wdata[%0d] cyc=%0d got=%h exp=%h", g, cyc, mem_wdata[g], e_wdata); end
            end
            checks++; if (if_rvalid[g] !== e_if_rv[g]) begin errors++; $display("FAIL if_rvalid[%0d] cyc=%0d got=%b exp=%b", g, cyc, if_rvalid[g], e_if_rv[g]); end
            checks++; if (if_rdata[g] !== e_if_rd[g]) begin errors++; $display("FAIL if_rdata[%0d] cyc=%0d got=%h exp=%h", g, cyc, if_rdata[g], e_if_rd[g]); end
            checks++; if (d_rvalid[g] !== e_d_rv[g]) begin errors++; $display("FAIL d_rvalid[%0d] cyc=%0d got=%b exp=%b", g, cyc, d_rvalid[g], e_d_rv[g]); end
            checks++; if (d_rdata[g] !== e_d_rd[g]) begin errors++; $display("FAIL d_rdata[%0d] cyc=%0d got=%h exp=%h", g, cyc, d_rdata[g], e_d_rd[g]); end
        end
    endtask

    task automatic tick();
        rsp_t r;
        @(posedge clk);
        if (rst) begin
            rq.delete();
            starve = 0;
        end else begin
            if (e_en && !e_we) begin
                for (int g = 0; g < NI; g++) begin
                    r.due = cyc + g + 1; r.inst = g; r.is_if = e_if_gnt; r.data = e_data; r.live = 1;
                    rq.push_back(r);
                end
            end
            if (e_if_gnt || !if_req) starve = 0;
            else if (e_d_gnt && starve < 4) starve++;
        end
        for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].due <= cyc) rq.delete(k);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        if_req = 0; d_req = 0; if_flush = 0;
        for (int i = 0; i < n; i++) begin settle(); tick(); end
    endtask

    task automatic set_d(input logic we, input logic [2:0] mode, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1; d_we = we; d_mode = mode; d_addr = a; d_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1; if_req = 1; if_addr = 32'h10; if_flush = 0;
        set_d(0, 3'b010, 32'h100, 32'h0);
        settle();
        for (int g = 0; g < NI; g++) begin
            checks++;
            if ({if_gnt[g], d_gnt[g], d_err[g], mem_en[g], mem_we[g], if_rvalid[g], d_rvalid[g]} !== 7'b0 ||
                mem_addr[g] !== 0 || mem_mode[g] !== 0 || mem_wdata[g] !== 0 || if_rdata[g] !== 0 || d_rdata[g] !== 0) begin
                errors++; $display("FAIL reset_outputs[%0d] got gnt=%b/%b en=%b addr=%h exp all zero", g, if_gnt[g], d_gnt[g], mem_en[g], mem_addr[g]);
            end
        end
        tick();
        rst = 0;
        idle(1);
        set_d(0, 3'b010, 32'h100, 32'h0);
        settle();
        checks++; if (d_gnt[1] !== 1'b1 || mem_en[1] !== 1'b1) begin errors++; $display("FAIL reset_load_gnt got d_gnt=%b mem_en=%b exp 1/1", d_gnt[1], mem_en[1]); end
        tick();
        d_req = 0; rst = 1;
        settle();
        checks++; if (d_rvalid[1] !== 1'b0 || d_rvalid[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_load got d_rvalid=%b/%b exp 0", d_rvalid[0], d_rvalid[1]); end
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (d_rvalid[1] !== 1'b0) begin errors++; $display("FAIL reset_no_resp cyc=%0d got d_rvalid=%b exp 0", cyc, d_rvalid[1]); end
            tick();
        end
    endtask

    task automatic test_conflict();
        idle(1);
        if_req = 1; if_addr = 32'h200;
        set_d(0, 3'b010, 32'h100, 32'h0);
        settle();
        checks++; if (d_gnt[0] !== 1'b1 || if_gnt[0] !== 1'b0) begin errors++; $display("FAIL conflict_first got d_gnt=%b if_gnt=%b exp 1/0", d_gnt[0], if_gnt[0]); end
        tick();
        d_req = 0;
        settle();
        checks++; if (if_gnt[0] !== 1'b1) begin errors++; $display("FAIL conflict_fetch_next got if_gnt=%b exp 1", if_gnt[0]); end
        checks++; if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_d_resp got v=%b d=%h exp 1/deadbeef", d_rvalid[0], d_rdata[0]); end
        tick();
        if_req = 0;
        settle();
        checks++; if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== 32'h00A00093) begin errors++; $display("FAIL conflict_if_resp got v=%b d=%h exp 1/00a00093", if_rvalid[0], if_rdata[0]); end
        tick();
    endtask

    task automatic test_starvation();
        idle(1);
        if_req = 1; if_addr = 32'h20;
        set_d(0, 3'b010, 32'h104, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (d_gnt[0] !== 1'b1 || if_gnt[0] !== 1'b0) begin errors++; $display("FAIL starve_data_%0d got d_gnt=%b if_gnt=%b exp 1/0", i, d_gnt[0], if_gnt[0]); end
            tick();
        end
        settle();
        checks++; if (if_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0) begin errors++; $display("FAIL starve_forced got if_gnt=%b d_gnt=%b exp 1/0", if_gnt[0], d_gnt[0]); end
        tick();
        settle();
        checks++; if (d_gnt[0] !== 1'b1 || if_gnt[0] !== 1'b0) begin errors++; $display("FAIL starve_cleared got d_gnt=%b if_gnt=%b exp 1/0", d_gnt[0], if_gnt[0]); end
        tick();
        idle(4);
    endtask

    task automatic test_flush();
        idle(1);
        for (int i = 0; i < 3; i++) begin
            if_req = 1; if_addr = 32'(i * 4);
            settle(); tick();
        end
        if_addr = 32'h40; if_flush = 1;
        settle();
        checks++; if (if_gnt[2] !== 1'b1 || if_rvalid[2] !== 1'b0) begin errors++; $display("FAIL flush_cycle got if_gnt=%b if_rvalid=%b exp 1/0", if_gnt[2], if_rvalid[2]); end
        tick();
        if_req = 0; if_flush = 0;
        for (int j = 0; j < 3; j++) begin
            settle();
            checks++;
            if (if_rvalid[2] !== (j == 2) || (j == 2 && if_rdata[2] !== 32'h12345678)) begin
                errors++; $display("FAIL flush_resp_%0d got v=%b d=%h exp v=%b", j, if_rvalid[2], if_rdata[2], (j == 2));
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_misalign();
        logic [7:0] old0, old1;
        old0 = mem[12'h102]; old1 = mem[12'h103];
        set_d(1, 3'b010, 32'h102, 32'h11223344);
        settle();
        checks++; if (d_gnt[0] !== 1'b1 || d_err[0] !== 1'b1 || mem_en[0] !== 1'b0) begin errors++; $display("FAIL misalign_sw got gnt=%b err=%b en=%b exp 1/1/0", d_gnt[0], d_err[0], mem_en[0]); end
        tick();
        checks++; if (mem[12'h102] !== old0 || mem[12'h103] !== old1) begin errors++; $display("FAIL misalign_mem got %h%h exp %h%h", mem[12'h103], mem[12'h102], old1, old0); end
        set_d(1, 3'b001, 32'h102, 32'h00005566);
        settle();
        checks++; if (d_gnt[0] !== 1'b1 || d_err[0] !== 1'b0 || mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1) begin errors++; $display("FAIL misalign_sh got gnt=%b err=%b en=%b we=%b exp 1/0/1/1", d_gnt[0], d_err[0], mem_en[0], mem_we[0]); end
        tick();
        checks++; if (mem[12'h102] !== 8'h66 || mem[12'h103] !== 8'h55) begin errors++; $display("FAIL sh_write got %h%h exp 5566", mem[12'h103], mem[12'h102]); end
        idle(1);
    endtask

    task automatic test_store();
        set_d(1, 3'b000, 32'h203, 32'h000000AB);
        settle();
        checks++; if (mem_we[0] !== 1'b1 || mem_mode[0] !== 3'b000 || d_gnt[0] !== 1'b1) begin errors++; $display("FAIL store_sb got we=%b mode=%b gnt=%b exp 1/000/1", mem_we[0], mem_mode[0], d_gnt[0]); end
        tick();
        set_d(0, 3'b100, 32'h203, 32'h0);
        settle();
        checks++; if (d_rvalid[0] !== 1'b0) begin errors++; $display("FAIL store_no_rvalid got %b exp 0", d_rvalid[0]); end
        tick();
        d_req = 0;
        settle();
        checks++; if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'h000000AB) begin errors++; $display("FAIL lbu_readback got v=%b d=%h exp 1/000000ab", d_rvalid[0], d_rdata[0]); end
        tick();
        idle(3);
    endtask

    task automatic test_random();
        logic [2:0] ld_m [5];
        ld_m = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if_req = 0; d_req = 0;
        e_if_gnt = 0; e_d_gnt = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!if_req || e_if_gnt) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 32'($urandom_range(0, 2047)) * 2;
            end
            if (!d_req || e_d_gnt) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_mode  = d_we ? 3'($urandom_range(0, 2)) : ld_m[$urandom_range(0, 4)];
                d_addr  = 32'($urandom_range(0, 4095));
                d_wdata = $urandom;
            end
            if_flush = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            settle();
            tick();
        end
        rst = 0;
        idle(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; starve = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} = 32'hDEADBEEF;
        {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]} = 32'h00A00093;
        {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]} = 32'h12345678;
        for (int g = 0; g < NI; g++) for (int i = 0; i < NI; i++) rd_pipe[g][i] = 32'h0;
        #1;
        test_reset();
        test_conflict();
        test_starvation();
        test_flush();
        test_misalign();
        test_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
